if_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the instruction ROM. Owns the PC, drives the ROM word address and captures {PC, instruction} pairs into a 2-entry fetch buffer. Presents them to decode over a valid/ready handshake. Accepts branch/jump redirects from execute, and halts or wraps at the end of the ROM image.

---
 rtl/if_fetch_ctrl_pkg.sv | 17 +
 rtl/if_fetch_ctrl_fetch_buf2.sv | 59 +++++
 rtl/if_fetch_ctrl.sv | 110 +++++++++++
 tb/tb_if_fetch_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch sequencer and its fetch buffer.
package if_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    PAUSE = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_ctrl_fetch_buf2.sv
// Two-entry FIFO for {pc, inst} pairs; entry 0 is always the head.
module fetch_buf2
  import if_fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_data,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic [1:0]   count_q, count_d;
  logic [1:0]   wr_idx;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    wr_idx  = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop && count_q != 2'd0) begin
        mem_d[0] = mem_q[1];
        count_d  = count_q - 2'd1;
        wr_idx   = count_q - 2'd1;
      end
      // A write into a full buffer is only legal when the head leaves in the same cycle.
      if (push && (count_q != 2'd2 || pop)) begin
        mem_d[wr_idx[0]] = wr_data;
        count_d          = count_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[0];
  assign count = count_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills a 2-entry buffer from the ROM
// and hands {pc, inst} to decode; redirects flush the buffer and reload the PC.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ROM_WORDS   = 32,
  parameter bit          HALT_AT_END = 1'b1,
  parameter int          CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Run,
  output logic [31:0]      InstAddr,
  input  logic [31:0]      Inst,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [31:0]      OutInst,
  output logic [31:0]      OutPc,
  input  logic             RedirValid,
  input  logic [31:0]      RedirTarget,
  output logic             Halted,
  output logic             MisalignErr,
  output logic [CNT_W-1:0] FetchCount
);

  localparam logic [31:0] LAST_PC = 32'(INST_BYTES * (ROM_WORDS - 1));
  localparam logic [31:0] STEP    = 32'(INST_BYTES);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  fetch_entry_t buf_head, buf_wr;
  logic [1:0]   buf_count;
  logic         buf_full, buf_empty;
  logic         pop, push, at_last;
  logic         unused_full;

  assign pop     = !buf_empty && OutReady;
  assign at_last = (pc_q == LAST_PC);
  // Fetch stops the same cycle Run drops so a paused core sees no new words.
  assign push    = !RedirValid && (state_q == FETCH) && Run &&
                   ((buf_count != 2'd2) || pop);
  assign buf_wr  = '{pc: pc_q, inst: Inst};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    if (RedirValid) begin
      state_d    = Run ? FETCH : PAUSE;
      pc_d       = {RedirTarget[31:2], 2'b00};
      misalign_d = misalign_q | (RedirTarget[1:0] != 2'b00);
    end else begin
      case (state_q)
        FETCH: begin
          if (!Run) state_d = PAUSE;
          else if (push && at_last && HALT_AT_END) state_d = HALT;
        end
        PAUSE:   if (Run) state_d = FETCH;
        default: state_d = HALT;
      endcase
      if (push) begin
        pc_d = (at_last && !HALT_AT_END) ? RESET_PC : pc_q + STEP;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  fetch_buf2 u_buf (
    .clk     (Clk),
    .rst     (Rst),
    .flush   (RedirValid),
    .push    (push),
    .pop     (pop),
    .wr_data (buf_wr),
    .head    (buf_head),
    .count   (buf_count),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  assign unused_full = buf_full;

  assign InstAddr    = pc_q;
  assign OutValid    = !buf_empty;
  assign OutInst     = buf_empty ? 32'h0 : buf_head.inst;
  assign OutPc       = buf_empty ? 32'h0 : buf_head.pc;
  assign Halted      = (state_q == HALT);
  assign MisalignErr = misalign_q;
  assign FetchCount  = cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a small combinational ROM model.
module tb_if_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Rst, Run, OutReady, RedirValid;
  logic [31:0] RedirTarget;
  logic [31:0] InstAddr, Inst, OutInst, OutPc;
  logic        OutValid, Halted, MisalignErr;
  logic [15:0] FetchCount;

  int n_run  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] rom(input logic [4:0] idx);
    case (idx)
      5'd0:    return 32'h2001_0008;
      5'd1:    return 32'h3402_000c;
      5'd2:    return 32'h0041_1822;
      5'd9:    return 32'h1026_fffe;
      default: return 32'hC0DE_0000 + {27'd0, idx};
    endcase
  endfunction

  assign Inst = rom(InstAddr[6:2]);

  if_fetch_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Run(Run), .InstAddr(InstAddr), .Inst(Inst),
    .OutValid(OutValid), .OutReady(OutReady), .OutInst(OutInst), .OutPc(OutPc),
    .RedirValid(RedirValid), .RedirTarget(RedirTarget), .Halted(Halted),
    .MisalignErr(MisalignErr), .FetchCount(FetchCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1; Run = 1'b1; OutReady = 1'b1; RedirValid = 1'b0; RedirTarget = 32'h0;
    #3;
    chk("rst_valid", {31'd0, OutValid}, 32'd0);
    chk("rst_inst", OutInst, 32'h0);
    chk("rst_pc", OutPc, 32'h0);
    chk("rst_halt", {31'd0, Halted}, 32'd0);
    chk("rst_mis", {31'd0, MisalignErr}, 32'd0);
    chk("rst_cnt", {16'd0, FetchCount}, 32'd0);
    chk("rst_addr", InstAddr, 32'h0);

    // Streaming fetch, decode always ready
    @(negedge Clk); Rst = 1'b0;
    step();
    chk("s0_valid", {31'd0, OutValid}, 32'd1);
    chk("s0_pc", OutPc, 32'h0);
    chk("s0_inst", OutInst, 32'h2001_0008);
    step();
    chk("s1_pc", OutPc, 32'h4);
    chk("s1_inst", OutInst, 32'h3402_000c);
    step();
    chk("s2_pc", OutPc, 32'h8);
    chk("s2_inst", OutInst, 32'h0041_1822);
    chk("s2_cnt", {16'd0, FetchCount}, 32'd3);

    // Back-pressure: buffer fills with 0x0/0x4 and the PC stalls at 0x8
    Rst = 1'b1; OutReady = 1'b0;
    @(negedge Clk); Rst = 1'b0;
    repeat (4) step();
    chk("bp_pc", OutPc, 32'h0);
    chk("bp_addr", InstAddr, 32'h8);
    chk("bp_cnt", {16'd0, FetchCount}, 32'd2);
    OutReady = 1'b1;
    chk("bp_head0", OutPc, 32'h0);
    step();
    chk("bp_head1", OutPc, 32'h4);
    step();
    chk("bp_head2", OutPc, 32'h8);
    chk("bp_head2_inst", OutInst, 32'h0041_1822);

    // Redirect with two entries buffered
    OutReady = 1'b0; RedirValid = 1'b1; RedirTarget = 32'h24;
    step();
    RedirValid = 1'b0;
    chk("rd_flush", {31'd0, OutValid}, 32'd0);
    chk("rd_addr", InstAddr, 32'h24);
    step();
    chk("rd_valid", {31'd0, OutValid}, 32'd1);
    chk("rd_pc", OutPc, 32'h24);
    chk("rd_inst", OutInst, 32'h1026_fffe);
    chk("rd_mis", {31'd0, MisalignErr}, 32'd0);

    // Misaligned redirect is forced to the word boundary and latches the error
    RedirValid = 1'b1; RedirTarget = 32'h26;
    step();
    RedirValid = 1'b0;
    chk("mis_set", {31'd0, MisalignErr}, 32'd1);
    chk("mis_addr", InstAddr, 32'h24);
    step();
    chk("mis_pc", OutPc, 32'h24);

    // Run to the last ROM word and halt
    OutReady = 1'b1; RedirValid = 1'b1; RedirTarget = 32'h70;
    step();
    RedirValid = 1'b0;
    repeat (4) step();
    chk("h_halt", {31'd0, Halted}, 32'd1);
    chk("h_pc", OutPc, 32'h7c);
    chk("h_addr", InstAddr, 32'h80);
    chk("h_cnt", {16'd0, FetchCount}, 32'd10);
    step();
    chk("h_drain", {31'd0, OutValid}, 32'd0);
    chk("h_hold", InstAddr, 32'h80);
    chk("h_stay", {31'd0, Halted}, 32'd1);
    chk("h_mis_sticky", {31'd0, MisalignErr}, 32'd1);
    RedirValid = 1'b1; RedirTarget = 32'h0;
    step();
    RedirValid = 1'b0;
    chk("h_exit", {31'd0, Halted}, 32'd0);
    step();
    chk("h_res_pc", OutPc, 32'h0);
    chk("h_res_inst", OutInst, 32'h2001_0008);

    // Asynchronous reset while full
    OutReady = 1'b0;
    step();
    step();
    chk("ar_full_pc", OutPc, 32'h0);
    Rst = 1'b1;
    #2;
    chk("ar_valid", {31'd0, OutValid}, 32'd0);
    chk("ar_halt", {31'd0, Halted}, 32'd0);
    chk("ar_cnt", {16'd0, FetchCount}, 32'd0);
    chk("ar_mis", {31'd0, MisalignErr}, 32'd0);
    @(negedge Clk); Rst = 1'b0; OutReady = 1'b1;
    step();
    chk("ar_restart", OutPc, 32'h0);

    // Pause: buffer drains, PC holds, resumes one cycle after Run returns
    Run = 1'b0;
    step();
    chk("p_drain", {31'd0, OutValid}, 32'd0);
    chk("p_addr", InstAddr, 32'h4);
    step();
    chk("p_hold", InstAddr, 32'h4);
    Run = 1'b1;
    step();
    chk("p_wake", {31'd0, OutValid}, 32'd0);
    step();
    chk("p_resume", OutPc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
